// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-look-ahead adder: group size,
// operation mode encodings and the 4-bit group propagate/generate terms.
package cla_pkg;

  localparam int CLA_GRP = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Group propagate: a carry passes through the whole group.
  function automatic logic grp_p(input logic [CLA_GRP-1:0] p);
    return &p;
  endfunction

  // Group generate: the group produces a carry on its own,
  // G = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0.
  function automatic logic grp_g(input logic [CLA_GRP-1:0] g,
                                 input logic [CLA_GRP-1:0] p);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < CLA_GRP; i++) begin
      acc = g[i] | (p[i] & acc);
    end
    return acc;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-look-ahead segment built from 4-bit groups,
// with a second look-ahead level across the groups of the segment.
module cla_segment
  import cla_pkg::*;
#(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic [SEG_W-1:0] c,
  output logic             co,
  output logic             c_msb_in
);

  localparam int NGRP = SEG_W / CLA_GRP;

  logic [SEG_W-1:0] w_p;
  logic [SEG_W-1:0] w_g;
  logic [NGRP-1:0]  w_gp;
  logic [NGRP-1:0]  w_gg;
  logic [NGRP:0]    w_gc;
  logic [SEG_W-1:0] w_cin;
  logic [SEG_W-1:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    assign w_gp[gi] = grp_p(w_p[gi*CLA_GRP +: CLA_GRP]);
    assign w_gg[gi] = grp_g(w_g[gi*CLA_GRP +: CLA_GRP], w_p[gi*CLA_GRP +: CLA_GRP]);
  end

  // Second-level look-ahead: carry into each group as a sum of products of
  // group terms and the segment carry-in, not a ripple through the groups.
  always_comb begin : b_group_carry
    logic acc;
    logic run_p;
    // NOTE: every variable gets a default before any loop or branch so no
    // path leaves one unassigned and infers a latch.
    acc   = 1'b0;
    run_p = 1'b0;
    w_gc  = '0;
    w_gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      // NOTE: blocking assignments here, so each term builds on the previous
      // one within this evaluation; clocked state elsewhere uses <=.
      acc   = w_gg[j];
      run_p = w_gp[j];
      for (int i = j - 1; i >= 0; i--) begin
        acc   = acc | (run_p & w_gg[i]);
        run_p = run_p & w_gp[i];
      end
      w_gc[j+1] = acc | (run_p & ci);
    end
  end

  // Per-bit carries inside each group, seeded by the look-ahead group carry.
  always_comb begin : b_bit_carry
    logic cc;
    cc    = 1'b0;
    w_cin = '0;
    w_c   = '0;
    for (int gi = 0; gi < NGRP; gi++) begin
      cc = w_gc[gi];
      for (int k = 0; k < CLA_GRP; k++) begin
        w_cin[gi*CLA_GRP + k] = cc;
        cc = w_g[gi*CLA_GRP + k] | (w_p[gi*CLA_GRP + k] & cc);
        w_c[gi*CLA_GRP + k] = cc;
      end
    end
  end

  assign s        = w_p ^ w_cin;
  assign c        = w_c;
  assign co       = w_gc[NGRP];
  assign c_msb_in = w_cin[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one SEG_W segment per stage, operands
// skewed in, results deskewed out, valid/ready handshake on both sides with
// a single global advance signal.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] carry,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;

  if (((WIDTH % SEG_W) != 0) || ((SEG_W % CLA_GRP) != 0)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
  end

  // Rank r of w_vld/w_cy is the register rank feeding stage r; rank NSEG is
  // the output rank (out_valid / cout).
  logic            w_adv;
  logic [NSEG:0]   w_vld;
  logic [NSEG:0]   w_cy;
  logic            w_ovf_nxt;
  logic            r_vld0;
  logic            r_cy0;
  logic            r_ovf;

  // The whole pipeline moves together: it advances unless a result is
  // waiting that the consumer will not take.
  assign w_adv    = !w_vld[NSEG] || out_ready;
  assign in_ready = w_adv;

  assign w_vld[0]  = r_vld0;
  assign w_cy[0]   = r_cy0;
  assign out_valid = w_vld[NSEG];
  assign cout      = w_cy[NSEG];
  assign ovf       = r_ovf;

  // Input rank valid and effective carry-in, plus the output overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld0 <= 1'b0;
      r_cy0  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv) begin
      r_vld0 <= in_valid;
      r_cy0  <= (sub == MODE_ADD) ? cin : ~cin;
      r_ovf  <= w_ovf_nxt;
    end
  end

  for (genvar j = 0; j < NSEG; j++) begin : g_seg
    localparam int LO   = j * SEG_W;
    localparam int NDSK = NSEG - j;

    logic [SEG_W-1:0] r_a_sk [0:j];
    logic [SEG_W-1:0] r_b_sk [0:j];
    logic [SEG_W-1:0] r_s_dk [0:NDSK-1];
    logic [SEG_W-1:0] r_c_dk [0:NDSK-1];
    logic             r_vld;
    logic             r_cy;
    logic [SEG_W-1:0] w_s;
    logic [SEG_W-1:0] w_c;
    logic             w_co;
    logic             w_msb_in;

    cla_segment #(
      .SEG_W(SEG_W)
    ) u_seg (
      .a       (r_a_sk[j]),
      .b       (r_b_sk[j]),
      .ci      (w_cy[j]),
      .s       (w_s),
      .c       (w_c),
      .co      (w_co),
      .c_msb_in(w_msb_in)
    );

    // Operand skew chain, stage valid/carry, and result deskew chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: the datapath chains are cleared along with the valid bits so
        // that s/carry/cout/ovf read zero after reset and no stale operand
        // can drift into the output rank behind a bubble.
        for (int i = 0; i <= j; i++) begin
          r_a_sk[i] <= '0;
          r_b_sk[i] <= '0;
        end
        for (int i = 0; i < NDSK; i++) begin
          r_s_dk[i] <= '0;
          r_c_dk[i] <= '0;
        end
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
      end else if (w_adv) begin
        r_a_sk[0] <= a[LO +: SEG_W];
        r_b_sk[0] <= (sub == MODE_SUB) ? ~b[LO +: SEG_W] : b[LO +: SEG_W];
        for (int i = 1; i <= j; i++) begin
          r_a_sk[i] <= r_a_sk[i-1];
          r_b_sk[i] <= r_b_sk[i-1];
        end
        r_vld     <= w_vld[j];
        r_cy      <= w_co;
        r_s_dk[0] <= w_s;
        r_c_dk[0] <= w_c;
        for (int i = 1; i < NDSK; i++) begin
          r_s_dk[i] <= r_s_dk[i-1];
          r_c_dk[i] <= r_c_dk[i-1];
        end
      end
    end

    assign w_vld[j+1]          = r_vld;
    assign w_cy[j+1]           = r_cy;
    assign s[LO +: SEG_W]      = r_s_dk[NDSK-1];
    assign carry[LO +: SEG_W]  = r_c_dk[NDSK-1];

    // Only the top segment's MSB carries decide signed overflow.
    if (j == NSEG - 1) begin : g_last
      assign w_ovf_nxt = w_co ^ w_msb_in;
    end else begin : g_mid
      logic w_unused_msb_in;
      assign w_unused_msb_in = w_msb_in;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: three configurations (64/16,
// 32/8, 64/64) share stimulus; a select picks which one is driven/observed.
module tb_pipelined_cla_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic [1:0]  sel;

  int n_tests;
  int n_fail;

  // DUT 0: WIDTH=64, SEG_W=16
  logic        d0_in_ready, d0_out_valid, d0_cout, d0_ovf;
  logic [63:0] d0_s, d0_carry;
  // DUT 1: WIDTH=32, SEG_W=8
  logic        d1_in_ready, d1_out_valid, d1_cout, d1_ovf;
  logic [31:0] d1_s, d1_carry;
  // DUT 2: WIDTH=64, SEG_W=64
  logic        d2_in_ready, d2_out_valid, d2_cout, d2_ovf;
  logic [63:0] d2_s, d2_carry;

  logic iv0, iv1, iv2;
  assign iv0 = in_valid && (sel == 2'd0);
  assign iv1 = in_valid && (sel == 2'd1);
  assign iv2 = in_valid && (sel == 2'd2);

  pipelined_cla_adder #(.WIDTH(64), .SEG_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(d0_in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(d0_out_valid), .out_ready(out_ready),
    .s(d0_s), .carry(d0_carry), .cout(d0_cout), .ovf(d0_ovf)
  );

  pipelined_cla_adder #(.WIDTH(32), .SEG_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(d1_in_ready),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(d1_out_valid), .out_ready(out_ready),
    .s(d1_s), .carry(d1_carry), .cout(d1_cout), .ovf(d1_ovf)
  );

  pipelined_cla_adder #(.WIDTH(64), .SEG_W(64)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(d2_in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .s(d2_s), .carry(d2_carry), .cout(d2_cout), .ovf(d2_ovf)
  );

  logic        obs_in_ready, obs_out_valid, obs_cout, obs_ovf;
  logic [63:0] obs_s, obs_carry;

  always_comb begin
    obs_in_ready  = d0_in_ready;
    obs_out_valid = d0_out_valid;
    obs_s         = d0_s;
    obs_carry     = d0_carry;
    obs_cout      = d0_cout;
    obs_ovf       = d0_ovf;
    case (sel)
      2'd1: begin
        obs_in_ready  = d1_in_ready;
        obs_out_valid = d1_out_valid;
        obs_s         = {32'b0, d1_s};
        obs_carry     = {32'b0, d1_carry};
        obs_cout      = d1_cout;
        obs_ovf       = d1_ovf;
      end
      2'd2: begin
        obs_in_ready  = d2_in_ready;
        obs_out_valid = d2_out_valid;
        obs_s         = d2_s;
        obs_carry     = d2_carry;
        obs_cout      = d2_cout;
        obs_ovf       = d2_ovf;
      end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-serial ripple reference over the low w bits.
  function automatic void model(input logic [63:0] ma, input logic [63:0] mb,
                                input logic mc, input logic ms, input int w,
                                output logic [63:0] rs, output logic [63:0] rc,
                                output logic rco, output logic rov);
    logic        cc;
    logic [63:0] bb;
    bb = ms ? ~mb : mb;
    cc = ms ? ~mc : mc;
    rs = '0;
    rc = '0;
    for (int i = 0; i < w; i++) begin
      rs[i] = ma[i] ^ bb[i] ^ cc;
      cc    = (ma[i] & bb[i]) | (ma[i] & cc) | (bb[i] & cc);
      rc[i] = cc;
    end
    rco = cc;
    rov = (ma[w-1] == bb[w-1]) && (rs[w-1] != ma[w-1]);
  endfunction

  // One operation through DUT 0 with hand-computed expectations.
  task automatic run_one(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tc, input logic ts, input logic [63:0] es,
                         input logic [63:0] ec, input logic eco, input logic eov);
    int lat;
    sel = 2'd0; out_ready = 1'b1;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    lat = 0;
    while (!obs_out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_s"}, obs_s, es);
    check({tag, "_carry"}, obs_carry, ec);
    check({tag, "_cout"}, 64'(obs_cout), 64'(eco));
    check({tag, "_ovf"}, 64'(obs_ovf), 64'(eov));
    @(posedge clk); #1;
  endtask

  // 8 back-to-back random operations, out_ready low for cycles 6..8.
  task automatic bp_test(input logic [1:0] which, input int w, input string tag);
    logic [63:0] qa [8];
    logic [63:0] qb [8];
    logic        qc [8];
    logic        qs [8];
    logic [63:0] es, ec;
    logic        eco, eov;
    int          sent, got, n_stall;
    sel = which;
    for (int i = 0; i < 8; i++) begin
      qa[i] = {$urandom(), $urandom()};
      qb[i] = {$urandom(), $urandom()};
      qc[i] = 1'($urandom_range(0, 1));
      qs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; n_stall = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = qa[sent]; b = qb[sent]; cin = qc[sent]; sub = qs[sent];
      end else begin
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      end
      #1;
      if (obs_out_valid && got < 8) begin
        model(qa[got], qb[got], qc[got], qs[got], w, es, ec, eco, eov);
        check({tag, "_s"}, obs_s, es);
        check({tag, "_carry"}, obs_carry, ec);
        check({tag, "_cout_ovf"}, 64'({obs_cout, obs_ovf}), 64'({eco, eov}));
        if (out_ready) begin
          got++;
        end else begin
          n_stall++;
          check({tag, "_in_ready_stall"}, 64'(obs_in_ready), 64'd0);
        end
      end
      if (in_valid && obs_in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check({tag, "_results"}, 64'(got), 64'd8);
    check({tag, "_stall_cycles"}, 64'(n_stall), 64'd3);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_valid;
    int first_k;
    n_tests = 0; n_fail = 0;
    sel = 2'd0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 64'(obs_out_valid), 64'd0);
    check("reset_s", obs_s, 64'd0);
    check("reset_carry", obs_carry, 64'd0);
    check("reset_cout_ovf", 64'({obs_cout, obs_ovf}), 64'd0);
    check("reset_in_ready", 64'(obs_in_ready), 64'd1);

    run_one("add_nocarry", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0);
    run_one("full_ripple", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
            64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b0, 1'b0);
    run_one("sub_cin", 64'd7, 64'd5, 1'b1, 1'b1,
            64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    run_one("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
            64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_one("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1);

    bp_test(2'd0, 64, "bp_w64_s16");
    bp_test(2'd1, 32, "bp_w32_s8");
    bp_test(2'd2, 64, "bp_w64_s64");

    // Reset with three operations in flight.
    sel = 2'd0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = 64'hDEAD_0000_0000_0001 + 64'(k); b = 64'h1111_2222_3333_4444; cin = 1'b1; sub = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    a = 64'h5555_5555_5555_5555; b = 64'h5555_5555_5555_5555;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    check("midrst_out_valid", 64'(obs_out_valid), 64'd0);
    check("midrst_s", obs_s, 64'd0);
    check("midrst_carry", obs_carry, 64'd0);
    check("midrst_cout_ovf", 64'({obs_cout, obs_ovf}), 64'd0);
    check("midrst_in_ready", 64'(obs_in_ready), 64'd1);
    in_valid = 1'b1; a = 64'h1234; b = 64'h1; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    n_valid = 0; first_k = -1;
    for (int k = 0; k < 10; k++) begin
      if (obs_out_valid) begin
        n_valid++;
        if (first_k < 0) begin
          first_k = k;
          check("midrst_new_s", obs_s, 64'h1235);
          check("midrst_new_carry", obs_carry, 64'h0);
        end
      end
      @(posedge clk); #1;
    end
    check("midrst_valid_count", 64'(n_valid), 64'd1);
    check("midrst_new_latency", 64'(first_k), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-look-ahead adder/subtractor: the next generation of the team's 64-bit combinational CLA. The operand width is split into equal segments, one segment resolved per pipeline stage, with the carry passed forward between stages. This gives full throughput (one operation per cycle) at a clock rate set by one segment rather than the full width. It sits between operand registers and a result consumer, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 64, operand/result width in bits
- SEG_W, 16, bits resolved per pipeline stage; WIDTH % SEG_W == 0 and SEG_W % 4 == 0 (elaboration error otherwise)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  operands accepted this cycle when in_valid && in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result when out_valid && out_ready
- s  out  WIDTH  sum/difference
- carry  out  WIDTH  carry out of each bit position i (carry[WIDTH-1] == cout)
- cout  out  1  final carry; in sub mode 1 = no borrow
- ovf  out  1  signed overflow

## Operation
- NSEG = WIDTH/SEG_W stages; stage k (0..NSEG-1) adds bits [k·SEG_W +: SEG_W].
- Effective B: b when sub=0; ~b when sub=1. Effective carry-in: cin when sub=0; ~cin when sub=1. Result = A − B − cin mod 2^WIDTH.
- Each segment is a 4-bit-group CLA: group P/G terms plus second-level look-ahead across groups inside the segment. The segment carry-in comes from the previous stage's registered carry-out.
- Input skew: the upper segments' effective-A/B are carried in pipeline registers until their stage.
- Output deskew: lower segment sums and carry bits are carried forward, so s/carry/cout/ovf present one coherent result.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- The valid bit travels with each stage.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stage registers load only when adv=1; when adv=0 everything holds, bubbles included.
- A bubble (in_valid=0 while adv=1) enters the pipeline as an invalid stage.

## Timing
- Latency NSEG cycles. Operand accepted at edge t → out_valid=1 with its result after edge t+NSEG, provided no stall. Default is 4.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: when out_valid=1 && out_ready=0:
  - s/carry/cout/ovf/out_valid are held stable.
  - in_ready=0.
  - No result is lost or duplicated.
- Simultaneous pop and push in the same cycle is allowed: full throughput with no bubble.
- Reset: rst=1 at an edge clears every stage valid bit and sets in_ready=1 combinationally afterwards. Outputs after reset: out_valid=0, s=0, carry=0, cout=0, ovf=0.
- Reset mid-operation discards all in-flight results. rst overrides in_valid on the same edge.
- Outputs are registered. in_ready depends combinationally on out_ready and out_valid only.

## Structure
- Shared package cla_pkg holds:
  - localparam CLA_GRP = 4
  - MODE_ADD = 1'b0, MODE_SUB = 1'b1
  - functions for group propagate/generate
- Sub-module cla_segment, combinational:
  - parameter SEG_W
  - inputs a, b, ci
  - outputs s[SEG_W], c[SEG_W] (per-bit carry-out), co, c_msb_in (carry into the segment MSB, used for ovf)
- Top instantiates NSEG cla_segment copies via generate, with stage/skew registers and the handshake.

## Test plan
- Add, no carry: a=0, b=64'hFFFF_FFFF_FFFF_FFFF, cin=0, sub=0 → s=all ones, carry=0, cout=0, ovf=0, out_valid 4 cycles after accept.
- Full ripple: same operands with cin=1 → s=0, carry=all ones, cout=1, ovf=0; confirms the carry crosses every stage boundary.
- Subtract with borrow: a=5, b=7, cin=0, sub=1 → s=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5, cin=1 → s=1, cout=1.
- Overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add → s=64'h8000_0000_0000_0000, ovf=1, cout=0. Also a=64'h8000_0000_0000_0000, b=1, sub → ovf=1.
- Backpressure: 8 back-to-back random operations, out_ready held low for 3 cycles mid-stream. Required: in_ready=0 during the stall, outputs held, all 8 results in order and matching the reference model. Repeat with WIDTH=32, SEG_W=8 (latency 4) and WIDTH=64, SEG_W=64 (latency 1).
- Reset mid-flight: assert rst for one cycle with 3 operations in flight → out_valid=0 and all outputs 0 next cycle, no stale result ever appears, and a new operation is accepted on the following cycle.
